cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the processor datapath: PC register, instruction memory, control unit, register file and ALU. Steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK. It generates the PC, instruction-register, register-file and flag write enables, and owns the NZCV flag register. It resolves conditional branches and stops on HALT or on an instruction-memory timeout.

Parameters:
MEM_TIMEOUT, 15, maximum FETCH cycles waiting for imem_ack before FAULT (1..255)
COND_W, 3, width of branch condition field

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
run  in  1  execution enable; level-sensitive
imem_ack  in  1  instruction memory returns valid word this cycle
is_halt  in  1  decoded instruction is HALT (control unit, combinational from IR)
is_branch  in  1  decoded instruction is a branch
branch_cond  in  COND_W  branch condition code
writes_reg  in  1  instruction writes rDestino
update_flags  in  1  instruction updates NZCV
alu_nzcv  in  4  ALU flags {N,Z,C,V} of current operation
imem_req  out  1  fetch request
ir_load  out  1  latch instruction register
rwe  out  1  register file write enable
pc_we  out  1  PC register load enable
pc_sel  out  1  0 = pc+4, 1 = branch target
flags  out  4  stored {N,Z,C,V}
state  out  3  current FSM state (debug)
fault  out  1  sticky fetch-timeout indication

Behaviour:
- Reset (async, immediate): state=IDLE, flags=0000, wait counter=0, all outputs 0. Applies at any point mid-instruction; no partial write completes.
- States (encoding in package): IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5, FAULT=6. Code 7 is illegal and goes to IDLE next cycle.
- IDLE: all enables 0. If run=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1 every cycle; wait counter clears on entry.
  - If imem_ack=1: ir_load=1 combinationally in the same cycle; next state DECODE.
  - Without ack, the counter increments. If the MEM_TIMEOUT-th FETCH cycle ends without ack, next state is FAULT.
  - An ack arriving on the MEM_TIMEOUT-th cycle is accepted.
- DECODE (1 cycle): if is_halt, go to HALTED, with no PC, register or flag write. Otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - Branch condition is evaluated against flags as they were before this cycle and registered internally.
  - If update_flags=1, flags<=alu_nzcv at the end of the cycle.
  - Next state WRITEBACK.
- WRITEBACK (1 cycle):
  - rwe=writes_reg; pc_we=1; pc_sel=is_branch & cond_met.
  - Next state FETCH if run=1, else IDLE. Deasserting run therefore always completes the current instruction.
- Condition codes:
  - 000 AL; 001 EQ (Z); 010 NE (!Z); 011 LT (N^V)
  - 100 GE (!(N^V)); 101 CS (C); 110 CC (!C); 111 NV (never)
- HALTED: all enables 0; stays until rst; run ignored.
- FAULT: fault=1, all enables 0; stays until rst.
- imem_ack outside FETCH is ignored. All other inputs are ignored outside the state that samples them.
- Throughput: 4 cycles per instruction plus FETCH wait cycles. rwe and pc_we are never high outside WRITEBACK. ir_load is never high outside FETCH.
- All outputs are registered state or simple decode of state plus same-cycle inputs; no combinational path from outputs back to inputs.

Decomposition:
- Package cpu_pkg holds:
  - state_t enum with the encodings above;
  - cond_t codes;
  - flag index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
- Sub-module branch_cond_eval: combinational (cond, nzcv) -> cond_met, reused later by a pipelined core.
- The FSM, wait counter and flag register stay in cpu_sequencer.

Test Plan:
1. Reset low, run=1, imem_ack=1 in FETCH, writes_reg=1 -> state sequence 1,2,3,4,1; rwe=1 and pc_we=1 only in cycle 4; pc_sel=0.
2. FETCH with ack delayed 3 cycles, MEM_TIMEOUT=15 -> imem_req high 4 cycles, ir_load single pulse in cycle 4, no fault. Ack withheld 15 cycles -> state=6, fault=1, stays there until rst.
3. Instruction A (update_flags=1, alu_nzcv=0100) then branch EQ -> pc_sel=1 in branch WRITEBACK. Repeat with alu_nzcv=0000 -> pc_sel=0. Branch with update_flags=1 uses the old flags.
4. Condition table sweep: all 8 codes × 16 flag values via branch_cond_eval -> matches LT=N^V and the rest of the table; NV is never taken.
5. is_halt=1 in DECODE -> state=5; pc_we and rwe stay 0; run toggling has no effect; rst returns state to 0.
6. rst asserted mid-EXECUTE with update_flags=1 -> outputs 0 and flags=0000 immediately (before the next edge). run dropped during EXECUTE -> WRITEBACK completes, then IDLE.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the multi-cycle sequencer: FSM state codes, branch
// condition codes and NZCV bit positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CC_AL = 3'd0,
    CC_EQ = 3'd1,
    CC_NE = 3'd2,
    CC_LT = 3'd3,
    CC_GE = 3'd4,
    CC_CS = 3'd5,
    CC_CC = 3'd6,
    CC_NV = 3'd7
  } cond_t;

  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control-unit/datapath signals seen by the sequencer; the slave side is the
// sequencer itself, the master side is whoever drives the decoded inputs.
interface cpu_sequencer_if #(
  parameter int unsigned COND_W = 3
);
  logic              run;
  logic              imem_ack;
  logic              is_halt;
  logic              is_branch;
  logic [COND_W-1:0] branch_cond;
  logic              writes_reg;
  logic              update_flags;
  logic [3:0]        alu_nzcv;

  logic              imem_req;
  logic              ir_load;
  logic              rwe;
  logic              pc_we;
  logic              pc_sel;
  logic [3:0]        flags;
  logic [2:0]        state;
  logic              fault;

  modport master (
    output run, imem_ack, is_halt, is_branch, branch_cond, writes_reg,
           update_flags, alu_nzcv,
    input  imem_req, ir_load, rwe, pc_we, pc_sel, flags, state, fault
  );

  modport slave (
    input  run, imem_ack, is_halt, is_branch, branch_cond, writes_reg,
           update_flags, alu_nzcv,
    output imem_req, ir_load, rwe, pc_we, pc_sel, flags, state, fault
  );
endinterface

// File: rtl/cpu_sequencer_branch_cond_eval.sv
// Combinational branch condition evaluation against a stored NZCV value.
module branch_cond_eval
  import cpu_pkg::*;
#(
  parameter int unsigned COND_W = 3
) (
  input  logic [COND_W-1:0] cond_i,
  input  logic [3:0]        nzcv_i,
  output logic              cond_met_o
);

  always_comb begin
    cond_met_o = 1'b0;
    case (cond_i)
      COND_W'(CC_AL): cond_met_o = 1'b1;
      COND_W'(CC_EQ): cond_met_o = nzcv_i[Z_IDX];
      COND_W'(CC_NE): cond_met_o = ~nzcv_i[Z_IDX];
      COND_W'(CC_LT): cond_met_o = nzcv_i[N_IDX] ^ nzcv_i[V_IDX];
      COND_W'(CC_GE): cond_met_o = ~(nzcv_i[N_IDX] ^ nzcv_i[V_IDX]);
      COND_W'(CC_CS): cond_met_o = nzcv_i[C_IDX];
      COND_W'(CC_CC): cond_met_o = ~nzcv_i[C_IDX];
      default:        cond_met_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with NZCV flag
// register, branch resolution, HALT and instruction-fetch timeout.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned COND_W      = 3
) (
  input  logic            clk,
  input  logic            rst,
  cpu_sequencer_if.slave  bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_met_q, cond_met_d;
  logic       cond_met;

  logic imem_req, ir_load, rwe, pc_we, pc_sel;

  branch_cond_eval #(.COND_W(COND_W)) u_cond (
    .cond_i     (bus.branch_cond),
    .nzcv_i     (flags_q),
    .cond_met_o (cond_met)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      flags_q    <= '0;
      cond_met_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      cond_met_q <= cond_met_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flags_d    = flags_q;
    cond_met_d = cond_met_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    rwe        = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else begin
          // cnt_q counts FETCH cycles already ended without ack
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == WAIT_LAST) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        state_d = bus.is_halt ? S_HALTED : S_EXECUTE;
      end
      S_EXECUTE: begin
        // sampled from the pre-update flags so a flag-setting branch sees old NZCV
        cond_met_d = cond_met;
        if (bus.update_flags) flags_d = bus.alu_nzcv;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        rwe    = bus.writes_reg;
        pc_we  = 1'b1;
        pc_sel = bus.is_branch & cond_met_q;
        cnt_d  = '0;
        state_d = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALTED: ;
      S_FAULT:  ;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.imem_req = imem_req;
  assign bus.ir_load  = ir_load;
  assign bus.rwe      = rwe;
  assign bus.pc_we    = pc_we;
  assign bus.pc_sel   = pc_sel;
  assign bus.flags    = flags_q;
  assign bus.state    = state_q;
  assign bus.fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed per-cycle expectations are
// queued by the stimulus process and checked by a negedge monitor.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.COND_W(3)) bus ();

  cpu_sequencer #(.MEM_TIMEOUT(15), .COND_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [2:0] sw_cond;
  logic [3:0] sw_nzcv;
  logic       sw_met;

  branch_cond_eval #(.COND_W(3)) u_sweep (
    .cond_i     (sw_cond),
    .nzcv_i     (sw_nzcv),
    .cond_met_o (sw_met)
  );

  typedef struct {
    string       nm;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [13:0] actual();
    return {bus.state, bus.imem_req, bus.ir_load, bus.rwe, bus.pc_we,
            bus.pc_sel, bus.flags, bus.fault};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (actual() !== e.v) begin
        n_bad++;
        $display("FAIL %s: got {st,req,irl,rwe,pcwe,sel,nzcv,flt}=%b required %b",
                 e.nm, actual(), e.v);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input state_t st, input bit req, input bit irl,
                     input bit rwe, input bit pcwe, input bit sel, input logic [3:0] fl);
    exp_t e;
    e.nm = nm;
    e.v  = {st, req, irl, rwe, pcwe, sel, fl, st == S_FAULT};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_cond(input int unsigned c, input logic [3:0] f);
    case (c)
      0: return 1'b1;
      1: return f[2];
      2: return !f[2];
      3: return f[3] != f[0];
      4: return f[3] == f[0];
      5: return f[1];
      6: return !f[1];
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    bus.run = 0; bus.imem_ack = 0; bus.is_halt = 0; bus.is_branch = 0;
    bus.branch_cond = 3'd0; bus.writes_reg = 0; bus.update_flags = 0;
    bus.alu_nzcv = 4'h0;
    sw_cond = '0; sw_nzcv = '0;

    repeat (2) @(posedge clk);
    #1;
    cyc("reset", S_IDLE, 0,0,0,0,0, 4'h0);
    rst = 0;
    cyc("idle_norun", S_IDLE, 0,0,0,0,0, 4'h0);

    // basic instruction, immediate ack
    bus.run = 1; bus.writes_reg = 1; bus.imem_ack = 1;
    cyc("t1_idle",  S_IDLE,      0,0,0,0,0, 4'h0);
    cyc("t1_fetch", S_FETCH,     1,1,0,0,0, 4'h0);
    cyc("t1_dec",   S_DECODE,    0,0,0,0,0, 4'h0);
    cyc("t1_exe",   S_EXECUTE,   0,0,0,0,0, 4'h0);
    cyc("t1_wb",    S_WRITEBACK, 0,0,1,1,0, 4'h0);

    // ack delayed by 3 cycles
    bus.imem_ack = 0; bus.writes_reg = 0;
    for (int unsigned i = 0; i < 3; i++) cyc("t2_wait", S_FETCH, 1,0,0,0,0, 4'h0);
    bus.imem_ack = 1;
    cyc("t2_ack",   S_FETCH,     1,1,0,0,0, 4'h0);
    cyc("t2_dec",   S_DECODE,    0,0,0,0,0, 4'h0);
    cyc("t2_exe",   S_EXECUTE,   0,0,0,0,0, 4'h0);
    cyc("t2_wb",    S_WRITEBACK, 0,0,0,1,0, 4'h0);

    // ack on the last permitted FETCH cycle is accepted
    bus.imem_ack = 0;
    for (int unsigned i = 0; i < 14; i++) cyc("tb_wait", S_FETCH, 1,0,0,0,0, 4'h0);
    bus.imem_ack = 1;
    cyc("tb_ack15", S_FETCH,     1,1,0,0,0, 4'h0);
    cyc("tb_dec",   S_DECODE,    0,0,0,0,0, 4'h0);
    cyc("tb_exe",   S_EXECUTE,   0,0,0,0,0, 4'h0);
    cyc("tb_wb",    S_WRITEBACK, 0,0,0,1,0, 4'h0);

    // A: set Z
    bus.update_flags = 1; bus.alu_nzcv = 4'b0100;
    cyc("t3a_fetch", S_FETCH,     1,1,0,0,0, 4'h0);
    cyc("t3a_dec",   S_DECODE,    0,0,0,0,0, 4'h0);
    cyc("t3a_exe",   S_EXECUTE,   0,0,0,0,0, 4'h0);
    cyc("t3a_wb",    S_WRITEBACK, 0,0,0,1,0, 4'b0100);
    // B: BEQ that also clears flags; decision uses old Z=1
    bus.is_branch = 1; bus.branch_cond = 3'b001; bus.alu_nzcv = 4'b0000;
    cyc("t3b_fetch", S_FETCH,     1,1,0,0,0, 4'b0100);
    cyc("t3b_dec",   S_DECODE,    0,0,0,0,0, 4'b0100);
    cyc("t3b_exe",   S_EXECUTE,   0,0,0,0,0, 4'b0100);
    cyc("t3b_wb",    S_WRITEBACK, 0,0,0,1,1, 4'b0000);
    // C: BEQ with Z=0, not taken
    bus.update_flags = 0;
    cyc("t3c_fetch", S_FETCH,     1,1,0,0,0, 4'h0);
    cyc("t3c_dec",   S_DECODE,    0,0,0,0,0, 4'h0);
    cyc("t3c_exe",   S_EXECUTE,   0,0,0,0,0, 4'h0);
    cyc("t3c_wb",    S_WRITEBACK, 0,0,0,1,0, 4'h0);

    // fetch timeout
    bus.is_branch = 0; bus.imem_ack = 0;
    for (int unsigned i = 0; i < 15; i++) cyc("to_wait", S_FETCH, 1,0,0,0,0, 4'h0);
    bus.imem_ack = 1;
    for (int unsigned i = 0; i < 4; i++) begin
      bus.run = i[0];
      cyc("to_fault", S_FAULT, 0,0,0,0,0, 4'h0);
    end
    rst = 1; bus.run = 0;
    cyc("to_rst", S_IDLE, 0,0,0,0,0, 4'h0);
    rst = 0;

    // HALT
    bus.run = 1; bus.is_halt = 1; bus.writes_reg = 1;
    cyc("h_idle",  S_IDLE,   0,0,0,0,0, 4'h0);
    cyc("h_fetch", S_FETCH,  1,1,0,0,0, 4'h0);
    cyc("h_dec",   S_DECODE, 0,0,0,0,0, 4'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      bus.run = i[0];
      cyc("h_halted", S_HALTED, 0,0,0,0,0, 4'h0);
    end
    rst = 1;
    cyc("h_rst", S_IDLE, 0,0,0,0,0, 4'h0);
    rst = 0; bus.is_halt = 0;

    // establish nonzero flags, then reset in the middle of EXECUTE
    bus.run = 1; bus.update_flags = 1; bus.alu_nzcv = 4'b1111;
    cyc("r_idle",  S_IDLE,      0,0,0,0,0, 4'h0);
    cyc("r_fetch", S_FETCH,     1,1,0,0,0, 4'h0);
    cyc("r_dec",   S_DECODE,    0,0,0,0,0, 4'h0);
    cyc("r_exe",   S_EXECUTE,   0,0,0,0,0, 4'h0);
    cyc("r_wb",    S_WRITEBACK, 0,0,1,1,0, 4'hF);
    bus.alu_nzcv = 4'b1010;
    cyc("r2_fetch", S_FETCH,  1,1,0,0,0, 4'hF);
    cyc("r2_dec",   S_DECODE, 0,0,0,0,0, 4'hF);
    chk("r2_in_exe", 32'(bus.state), 32'(S_EXECUTE));
    #2 rst = 1;
    #1 chk("async_rst_mid_exe", 32'(actual()), 32'h0);
    @(posedge clk);
    #1 rst = 0;

    // run dropped during EXECUTE: instruction completes, then IDLE
    cyc("d_idle",  S_IDLE,   0,0,0,0,0, 4'h0);
    cyc("d_fetch", S_FETCH,  1,1,0,0,0, 4'h0);
    cyc("d_dec",   S_DECODE, 0,0,0,0,0, 4'h0);
    bus.run = 0;
    cyc("d_exe",   S_EXECUTE,   0,0,0,0,0, 4'h0);
    cyc("d_wb",    S_WRITEBACK, 0,0,1,1,0, 4'b1010);
    cyc("d_idle1", S_IDLE,      0,0,0,0,0, 4'b1010);
    cyc("d_idle2", S_IDLE,      0,0,0,0,0, 4'b1010);

    @(posedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // condition table sweep
    for (int unsigned c = 0; c < 8; c++) begin
      for (int unsigned f = 0; f < 16; f++) begin
        sw_cond = 3'(c);
        sw_nzcv = 4'(f);
        #1;
        chk($sformatf("cond_%0d_nzcv_%h", c, f), 32'(sw_met), 32'(ref_cond(c, 4'(f))));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
